// File: rtl/chase_ctrl.sv
// chase_ctrl: start/pause/stop sequencer that moves one lit LED in left, right, bounce or hold mode.
// Optional feature macro CHASE_TRAIL_EN adds a two-LED trail behind the lit position.
module chase_ctrl #(
    parameter int N_LEDS   = 16,
    parameter int MAX_LAPS = 0,
    parameter int PW       = $clog2(N_LEDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic [PW-1:0]     pos,
    output logic              busy,
    output logic              lap_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0]    M_LEFT   = 2'b00;
    localparam logic [1:0]    M_RIGHT  = 2'b01;
    localparam logic [1:0]    M_BOUNCE = 2'b10;
    localparam int            LW       = (MAX_LAPS > 0) ? $clog2(MAX_LAPS + 1) : 1;
    localparam int            XW       = PW + 1;
    localparam logic [PW-1:0] POS_MAX  = PW'(N_LEDS - 1);
    localparam logic [LW-1:0] LAP_LIM  = LW'(MAX_LAPS);

    state_t              state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [LW-1:0]       lap_cnt_q, lap_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                busy_q, busy_d;
    logic                lap_done_q, lap_done_d;

    logic [PW-1:0]       step_pos_s, lap_pos_s;
    logic                step_dir_s, lap_dir_s, step_lap_s;
    logic                step_en_s, start_en_s;
    logic [N_LEDS-1:0]   trail_s;

    // Indices at or beyond N_LEDS yield no bit, which is how trail positions are dropped.
    function automatic logic [N_LEDS-1:0] bit_at(input logic [XW-1:0] idx);
        logic [N_LEDS-1:0] one_v;
        one_v = {{(N_LEDS-1){1'b0}}, 1'b1};
        if (idx < XW'(N_LEDS)) begin
            return one_v << idx;
        end else begin
            return '0;
        end
    endfunction

    // One step of travel in the latched mode, plus the post-lap position/direction for the newly sampled mode.
    always_comb begin
        step_pos_s = pos_q;
        step_dir_s = dir_q;
        step_lap_s = 1'b0;
        case (mode_q)
            M_LEFT: begin
                if (pos_q == POS_MAX) begin
                    step_pos_s = '0;
                    step_lap_s = 1'b1;
                end else begin
                    step_pos_s = pos_q + PW'(1);
                end
            end
            M_RIGHT: begin
                if (pos_q == '0) begin
                    step_pos_s = POS_MAX;
                    step_lap_s = 1'b1;
                end else begin
                    step_pos_s = pos_q - PW'(1);
                end
            end
            M_BOUNCE: begin
                if (dir_q) begin
                    if (pos_q == POS_MAX) begin
                        step_pos_s = pos_q - PW'(1);
                        step_dir_s = 1'b0;
                    end else begin
                        step_pos_s = pos_q + PW'(1);
                        step_dir_s = (pos_q != POS_MAX - PW'(1));
                    end
                end else begin
                    if (pos_q == '0) begin
                        step_pos_s = PW'(1);
                        step_dir_s = 1'b1;
                    end else begin
                        step_pos_s = pos_q - PW'(1);
                        step_dir_s = (pos_q == PW'(1));
                        step_lap_s = (pos_q == PW'(1));
                    end
                end
            end
            default: begin
                step_pos_s = pos_q;
            end
        endcase

        lap_pos_s = step_pos_s;
        lap_dir_s = 1'b1;
        case (mode)
            M_RIGHT: begin
                lap_dir_s = 1'b0;
                if (step_pos_s == '0) begin
                    lap_pos_s = POS_MAX;
                end else begin
                    lap_pos_s = step_pos_s;
                end
            end
            M_BOUNCE: lap_dir_s = (step_pos_s != POS_MAX);
            default:  lap_dir_s = 1'b1;
        endcase
    end

    // Sequencer: abort first, then per-state start/stop/step handling.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        lap_cnt_d  = lap_cnt_q;
        mode_d     = mode_q;
        lap_done_d = 1'b0;
        step_en_s  = 1'b0;
        start_en_s = 1'b0;
        if (abort) begin
            state_d   = ST_IDLE;
            pos_d     = '0;
            lap_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        start_en_s = 1'b1;
                        mode_d     = mode;
                        pos_d      = (mode == M_RIGHT) ? POS_MAX : '0;
                        dir_d      = (mode != M_RIGHT);
                        lap_cnt_d  = '0;
                        state_d    = stop ? ST_PAUSE : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (step_tick) begin
                        step_en_s = 1'b1;
                        if (step_lap_s) begin
                            lap_done_d = 1'b1;
                            mode_d     = mode;
                            pos_d      = lap_pos_s;
                            dir_d      = lap_dir_s;
                            lap_cnt_d  = lap_cnt_q + LW'(1);
                            if ((MAX_LAPS != 0) && (lap_cnt_q + LW'(1) == LAP_LIM)) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            pos_d = step_pos_s;
                            dir_d = step_dir_s;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (!stop) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef CHASE_TRAIL_EN
    logic           trail_up_q, trail_up_d;
    logic [XW-1:0]  pos_x_s, tr_a_s, tr_b_s;

    // Remember which way the last move went so bounce trails follow a flip immediately.
    always_comb begin
        if (start_en_s) begin
            trail_up_d = (mode != M_RIGHT);
        end else if (step_en_s) begin
            trail_up_d = (mode_q == M_BOUNCE) ? dir_q : (mode_q != M_RIGHT);
        end else begin
            trail_up_d = trail_up_q;
        end
    end

    // Trail positions behind the next lit position; out-of-range indices are dropped by bit_at.
    always_comb begin
        pos_x_s = {1'b0, pos_d};
        tr_a_s  = XW'(N_LEDS);
        tr_b_s  = XW'(N_LEDS);
        case (mode_d)
            M_LEFT: begin
                tr_a_s = (pos_x_s == '0) ? XW'(N_LEDS - 1) : pos_x_s - XW'(1);
                tr_b_s = (pos_x_s < XW'(2)) ? pos_x_s + XW'(N_LEDS - 2) : pos_x_s - XW'(2);
            end
            M_RIGHT: begin
                tr_a_s = (pos_x_s + XW'(1) >= XW'(N_LEDS)) ? pos_x_s + XW'(1) - XW'(N_LEDS) : pos_x_s + XW'(1);
                tr_b_s = (pos_x_s + XW'(2) >= XW'(N_LEDS)) ? pos_x_s + XW'(2) - XW'(N_LEDS) : pos_x_s + XW'(2);
            end
            M_BOUNCE: begin
                if (trail_up_d) begin
                    tr_a_s = (pos_x_s < XW'(1)) ? XW'(N_LEDS) : pos_x_s - XW'(1);
                    tr_b_s = (pos_x_s < XW'(2)) ? XW'(N_LEDS) : pos_x_s - XW'(2);
                end else begin
                    tr_a_s = pos_x_s + XW'(1);
                    tr_b_s = pos_x_s + XW'(2);
                end
            end
            default: begin
                tr_a_s = XW'(N_LEDS);
                tr_b_s = XW'(N_LEDS);
            end
        endcase
        trail_s = bit_at(tr_a_s) | bit_at(tr_b_s);
    end

    // Trail direction register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trail_up_q <= 1'b1;
        end else begin
            trail_up_q <= trail_up_d;
        end
    end
`else
    assign trail_s = '0;
`endif

    // Output images are computed from the next state so every output is a flop.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_IDLE) begin
            led_d = '0;
        end else begin
            led_d = bit_at({1'b0, pos_d}) | trail_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            dir_q      <= 1'b1;
            lap_cnt_q  <= '0;
            mode_q     <= 2'b00;
            led_q      <= '0;
            busy_q     <= 1'b0;
            lap_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            lap_cnt_q  <= lap_cnt_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            lap_done_q <= lap_done_d;
        end
    end

    assign led      = led_q;
    assign pos      = pos_q;
    assign busy     = busy_q;
    assign lap_done = lap_done_q;

endmodule

// File: tb/tb_chase_ctrl.sv
// Directed, table-driven bench for chase_ctrl: one free-running instance and one with a 2-lap limit.
module tb_chase_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_tick, start, stop, abort;
    logic [1:0]  mode;
    logic [15:0] led_a, led_b;
    logic [3:0]  pos_a, pos_b;
    logic        busy_a, busy_b, lap_a, lap_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chase_ctrl #(.N_LEDS(16), .MAX_LAPS(0)) dut (
        .clk(clk), .reset(reset), .step_tick(step_tick), .start(start), .stop(stop),
        .abort(abort), .mode(mode), .led(led_a), .pos(pos_a), .busy(busy_a), .lap_done(lap_a)
    );

    chase_ctrl #(.N_LEDS(16), .MAX_LAPS(2)) dut_l (
        .clk(clk), .reset(reset), .step_tick(step_tick), .start(start), .stop(stop),
        .abort(abort), .mode(mode), .led(led_b), .pos(pos_b), .busy(busy_b), .lap_done(lap_b)
    );

    typedef struct packed {
        logic        tk;
        logic        st;
        logic        sp;
        logic        ab;
        logic [1:0]  md;
        logic [3:0]  pos;
        logic [15:0] led;
        logic        busy;
        logic        lap;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic tk, st, sp, ab, input logic [1:0] md);
        step_tick = tk;
        start     = st;
        stop      = sp;
        abort     = ab;
        mode      = md;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] oh(input int p);
        logic [15:0] one_v;
        one_v = 16'h0001;
        return one_v << p;
    endfunction

    int exp_p;

    initial begin
        //             tk    st    sp    ab    md     pos    led        busy  lap
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0,  16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0,  16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 4'd15, 16'h8000, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'd14, 16'h4000, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 4'd13, 16'h2000, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 4'd13, 16'h2000, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd13, 16'h2000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd13, 16'h2000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'd12, 16'h1000, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'd0,  16'h0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 4'd0,  16'h0001, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0,  16'h0001, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0,  16'h0001, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'd0,  16'h0000, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0,  16'h0001, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1,  16'h0002, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'd2,  16'h0004, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0,  16'h0000, 1'b0, 1'b0};

        reset = 1'b0;
        step_tick = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pos", 32'(pos_a), 32'd0);
        chk("rst_led", 32'(led_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_lap", 32'(lap_a), 32'd0);
        #2 reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].tk, tbl[i].st, tbl[i].sp, tbl[i].ab, tbl[i].md);
            chk($sformatf("tbl%0d_pos", i), 32'(pos_a), 32'(tbl[i].pos));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_lap", i), 32'(lap_a), 32'(tbl[i].lap));
`ifndef CHASE_TRAIL_EN
            chk($sformatf("tbl%0d_led", i), 32'(led_a), 32'(tbl[i].led));
`endif
        end

        // Left run with a two-lap limit on dut_l
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("l_start_busy", 32'(busy_b), 32'd1);
`ifndef CHASE_TRAIL_EN
        chk("l_start_led", 32'(led_b), 32'h0001);
`endif
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
            chk($sformatf("l_lap_t%0d", k), 32'(lap_b), (k == 16 || k == 32) ? 32'd1 : 32'd0);
            chk($sformatf("l_busy_t%0d", k), 32'(busy_b), (k == 32) ? 32'd0 : 32'd1);
`ifndef CHASE_TRAIL_EN
            chk($sformatf("l_led_t%0d", k), 32'(led_b), (k == 32) ? 32'd0 : 32'(oh(k % 16)));
`endif
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("l_after_lap", 32'(lap_b), 32'd0);
        chk("l_after_busy", 32'(busy_b), 32'd0);

        // Bounce, no lap limit
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        chk("b_start_pos", 32'(pos_a), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
            exp_p = (k <= 15) ? k : ((k <= 30) ? 30 - k : 1);
            chk($sformatf("b_pos_t%0d", k), 32'(pos_a), 32'(exp_p));
            chk($sformatf("b_lap_t%0d", k), 32'(lap_a), (k == 30) ? 32'd1 : 32'd0);
`ifndef CHASE_TRAIL_EN
            chk($sformatf("b_led_t%0d", k), 32'(led_a), 32'(oh(exp_p)));
`endif
        end

        // Pause in right mode at position 9
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("p_pre_pos", 32'(pos_a), 32'd9);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        chk("p_stop_pos", 32'(pos_a), 32'd9);
        chk("p_stop_busy", 32'(busy_a), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
            chk($sformatf("p_hold%0d_pos", k), 32'(pos_a), 32'd9);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("p_release_pos", 32'(pos_a), 32'd9);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("p_resume_pos", 32'(pos_a), 32'd8);

        // Mid-lap mode change from left to right
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("m_pos5", 32'(pos_a), 32'd5);
        for (int k = 6; k <= 15; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
            chk($sformatf("m_pos_t%0d", k), 32'(pos_a), 32'(k));
            chk($sformatf("m_lap_t%0d", k), 32'(lap_a), 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("m_wrap_pos", 32'(pos_a), 32'd15);
        chk("m_wrap_lap", 32'(lap_a), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("m_dec1_pos", 32'(pos_a), 32'd14);
        chk("m_dec1_lap", 32'(lap_a), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("m_dec2_pos", 32'(pos_a), 32'd13);

        // Abort beats start and step in the same cycle
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        chk("a_pos", 32'(pos_a), 32'd0);
        chk("a_led", 32'(led_a), 32'd0);
        chk("a_busy", 32'(busy_a), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("a_restart_busy", 32'(busy_a), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("a_restart_pos", 32'(pos_a), 32'd1);

        // Asynchronous reset while running
        #2 reset = 1'b0;
        #1;
        chk("ar_pos", 32'(pos_a), 32'd0);
        chk("ar_led", 32'(led_a), 32'd0);
        chk("ar_busy", 32'(busy_a), 32'd0);
        step_tick = 1'b0; start = 1'b0; abort = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_idle_busy", 32'(busy_a), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("ar_start_busy", 32'(busy_a), 32'd1);
        chk("ar_start_pos", 32'(pos_a), 32'd0);

`ifdef CHASE_TRAIL_EN
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("t_left_led", 32'(led_a), 32'h8003);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        chk("t_idle_led", 32'(led_a), 32'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        repeat (15) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("t_top_led", 32'(led_a), 32'hE000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("t_flip_led", 32'(led_a), 32'hC000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
